// File: rtl/guess_pkg.sv
// Shared types and constants for the guess entry keypad front-end.
package guess_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ENTRY   = 2'd1,
        ST_FIRE    = 2'd2,
        ST_RELEASE = 2'd3
    } entry_state_t;

    typedef logic [3:0] bcd_t;

    localparam int MAX_DIGITS = 3;

    function automatic logic is_bcd(input bcd_t d);
        return d <= 4'd9;
    endfunction

endpackage

// File: rtl/guess_entry_button_conditioner.sv
// Enter push-button conditioning: 2-flop synchroniser, optional debounce
// (GUESS_ENTRY_DEBOUNCE_EN) and a registered rising-edge press pulse.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_level,
    output logic o_press
);

    logic       r_sync1;
    logic       r_sync2;
    logic       r_level_d;
    logic       r_press;
    logic       r_armed;
    logic [1:0] r_rdy;
    logic       w_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

`ifdef GUESS_ENTRY_DEBOUNCE_EN
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] r_db_cnt;
    logic             r_db_level;

    // Down-counter reloads whenever the synchronised level matches the accepted one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_db_cnt   <= '0;
            r_db_level <= 1'b0;
        end else if (r_sync2 == r_db_level) begin
            r_db_cnt   <= RELOAD;
        end else if (r_db_cnt == '0) begin
            r_db_level <= r_sync2;
            r_db_cnt   <= RELOAD;
        end else begin
            r_db_cnt   <= r_db_cnt - 1'b1;
        end
    end

    assign w_level = r_db_level;
`else
    assign w_level = r_sync2;
`endif

    // Presses are only honoured once the button has been seen released after
    // reset, so a button held through reset cannot fire on its own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy     <= 2'b00;
            r_armed   <= 1'b0;
            r_level_d <= 1'b0;
            r_press   <= 1'b0;
        end else begin
            r_rdy     <= {r_rdy[0], 1'b1};
            if (r_rdy[1] && !r_sync2 && !w_level) begin
                r_armed <= 1'b1;
            end
            r_level_d <= w_level;
            r_press   <= r_armed && w_level && !r_level_d;
        end
    end

    assign o_level = w_level;
    assign o_press = r_press;

endmodule

// File: rtl/guess_entry.sv
// Keypad guess entry: assembles up to three BCD digits and emits one confirm
// pulse per enter press. Debounce is compiled in with GUESS_ENTRY_DEBOUNCE_EN.
//
// state      | meaning
// -----------+-------------------------------------------------
// ST_IDLE    | no digits held, waiting for a digit
// ST_ENTRY   | collecting digits
// ST_FIRE    | confirmButton high for this one clock
// ST_RELEASE | waiting for the enter button to be let go
module guess_entry
    import guess_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       restart,
    input  logic [3:0] digit_in,
    input  logic       digit_valid,
    input  logic       enter_btn,
    input  logic       clear_btn,
    input  logic [1:0] Max_digit,
    output logic [3:0] key0,
    output logic [3:0] key1,
    output logic [3:0] key2,
    output logic       confirmButton,
    output logic [1:0] entry_count
);

    entry_state_t r_state, w_state_nxt;
    bcd_t         r_key0, r_key1, r_key2;
    bcd_t         w_key0_nxt, w_key1_nxt, w_key2_nxt;
    logic [1:0]   r_count, w_count_nxt;
    logic [1:0]   r_max_prev;
    logic         w_level;
    logic         w_press;
    logic         w_clear;
    logic         w_full;
    logic         w_digit_ok;

    button_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk     (clk),
        .rst_n   (restart),
        .i_btn   (enter_btn),
        .o_level (w_level),
        .o_press (w_press)
    );

    assign w_full     = (Max_digit != 2'd0) && (r_count == Max_digit);
    assign w_digit_ok = digit_valid && is_bcd(digit_in) && (r_count < Max_digit);
    // Retargeting the digit count mid-entry invalidates what was typed.
    assign w_clear    = clear_btn || ((r_state == ST_ENTRY) && (Max_digit != r_max_prev));

    always_ff @(posedge clk or negedge restart) begin
        if (!restart) begin
            r_state    <= ST_IDLE;
            r_key0     <= '0;
            r_key1     <= '0;
            r_key2     <= '0;
            r_count    <= 2'd0;
            r_max_prev <= 2'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_key0     <= w_key0_nxt;
            r_key1     <= w_key1_nxt;
            r_key2     <= w_key2_nxt;
            r_count    <= w_count_nxt;
            r_max_prev <= Max_digit;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_key0_nxt  = r_key0;
        w_key1_nxt  = r_key1;
        w_key2_nxt  = r_key2;
        w_count_nxt = r_count;
        unique case (r_state)
            ST_IDLE, ST_ENTRY: begin
                if (w_clear) begin
                    w_key0_nxt  = '0;
                    w_key1_nxt  = '0;
                    w_key2_nxt  = '0;
                    w_count_nxt = 2'd0;
                    w_state_nxt = w_level ? ST_RELEASE : ST_IDLE;
                end else if (w_press) begin
                    if (w_full) begin
                        w_state_nxt = ST_FIRE;
                    end
                end else if (w_digit_ok) begin
                    w_key2_nxt  = r_key1;
                    w_key1_nxt  = r_key0;
                    w_key0_nxt  = digit_in;
                    w_count_nxt = r_count + 2'd1;
                    w_state_nxt = ST_ENTRY;
                end
            end
            ST_FIRE: begin
                w_key0_nxt  = '0;
                w_key1_nxt  = '0;
                w_key2_nxt  = '0;
                w_count_nxt = 2'd0;
                w_state_nxt = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!w_level) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign key0          = r_key0;
    assign key1          = r_key1;
    assign key2          = r_key2;
    assign entry_count   = r_count;
    assign confirmButton = (r_state == ST_FIRE);

endmodule
